// File: rtl/ipmatch_gate.sv
// ipmatch_gate: holds the first DECIDE_AT bytes of each received packet
// until the upstream IP matcher's verdict is valid. It then forwards the
// packet cut-through or silently discards it.
// Optional build macro IPMATCH_GATE_STATS_EN adds passed/dropped packet counters.
module ipmatch_gate #(
  parameter int unsigned DECIDE_AT = 30,
  parameter int unsigned LGFIFO    = 5
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_no_match,
  input  logic       S_AXIN_VALID,
  input  logic [7:0] S_AXIN_DATA,
  input  logic       S_AXIN_LAST,
  input  logic       S_AXIN_ABORT,
  output logic       M_AXIN_VALID,
  output logic [7:0] M_AXIN_DATA,
  output logic       M_AXIN_LAST,
  output logic       M_AXIN_ABORT
`ifdef IPMATCH_GATE_STATS_EN
  ,
  output logic [31:0] o_pkts_passed,
  output logic [31:0] o_pkts_dropped
`endif
);

  localparam int unsigned     DEPTH      = 1 << LGFIFO;
  localparam logic [5:0]      DECIDE_CNT = 6'(DECIDE_AT);
  localparam logic [5:0]      DECIDE_M1  = 6'(DECIDE_AT - 1);
  localparam logic [LGFIFO:0] FULL_FILL  = (LGFIFO + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_HOLD,
    S_FORWARD,
    S_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [LGFIFO:0]   wr_q, wr_d;
  logic [LGFIFO:0]   rel_q, rel_d;
  logic [LGFIFO:0]   rd_q, rd_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [8:0]        fifo_q [DEPTH];
  logic              fifo_we;
  logic              out_valid_d, out_last_d, out_abort_d;
  logic [7:0]        out_data_d;
  logic [LGFIFO-1:0] wr_idx, rd_idx;
  logic [LGFIFO:0]   fill;
  logic              accept;
  logic              decide;

  assign wr_idx = wr_q[LGFIFO-1:0];
  assign rd_idx = rd_q[LGFIFO-1:0];
  assign fill   = wr_q - rd_q;
  assign accept = S_AXIN_VALID && !S_AXIN_ABORT;
  // Verdict edge: the byte that brings the count to DECIDE_AT, unless it also ends the packet
  assign decide = (state_q == S_HOLD) && accept && !S_AXIN_LAST && (cnt_q == DECIDE_M1);

  // Next-state, pointer and registered-output logic
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rel_d       = rel_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    fifo_we     = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_last_d  = 1'b0;
    out_abort_d = 1'b0;

    if (rd_q != rel_q) begin
      out_valid_d              = 1'b1;
      {out_last_d, out_data_d} = fifo_q[rd_idx];
      rd_d                     = rd_q + 1'b1;
    end

    if (S_AXIN_ABORT || (S_AXIN_VALID && S_AXIN_LAST)) begin
      cnt_d = '0;
    end else if (S_AXIN_VALID && (cnt_q != DECIDE_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      S_HOLD: begin
        if (S_AXIN_ABORT) begin
          wr_d = rel_q;
        end else if (S_AXIN_VALID) begin
          fifo_we = 1'b1;
          wr_d    = wr_q + 1'b1;
          if (S_AXIN_LAST) begin
            rel_d = wr_q + 1'b1;
          end else if (decide) begin
            if (i_no_match) begin
              wr_d    = rel_q;
              state_d = S_DROP;
            end else begin
              rel_d   = wr_q + 1'b1;
              state_d = S_FORWARD;
            end
          end
        end
      end
      S_FORWARD: begin
        if (S_AXIN_ABORT) begin
          // Flush overrides this cycle's read: nothing more of the packet may leave
          rel_d       = wr_q;
          rd_d        = wr_q;
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_last_d  = 1'b0;
          out_abort_d = 1'b1;
          state_d     = S_HOLD;
        end else if (S_AXIN_VALID) begin
          fifo_we = 1'b1;
          wr_d    = wr_q + 1'b1;
          rel_d   = wr_q + 1'b1;
          if (S_AXIN_LAST) begin
            state_d = S_HOLD;
          end
        end
      end
      S_DROP: begin
        if (S_AXIN_ABORT || (S_AXIN_VALID && S_AXIN_LAST)) begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  // State, pointers, count and output registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= S_HOLD;
      wr_q         <= '0;
      rel_q        <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      M_AXIN_VALID <= 1'b0;
      M_AXIN_DATA  <= '0;
      M_AXIN_LAST  <= 1'b0;
      M_AXIN_ABORT <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      rel_q        <= rel_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      M_AXIN_VALID <= out_valid_d;
      M_AXIN_DATA  <= out_data_d;
      M_AXIN_LAST  <= out_last_d;
      M_AXIN_ABORT <= out_abort_d;
    end
  end

  // FIFO storage, {LAST, DATA} per entry; contents need no reset
  always_ff @(posedge i_clk) begin
    if (fifo_we) begin
      fifo_q[wr_idx] <= {S_AXIN_LAST, S_AXIN_DATA};
    end
  end

  // Occupancy can never reach full depth when the input respects the byte-rate bound
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n) fill != FULL_FILL);

`ifdef IPMATCH_GATE_STATS_EN
  logic [31:0] passed_q, dropped_q;
  logic        pass_evt, drop_evt;

  assign pass_evt = accept && S_AXIN_LAST && (state_q != S_DROP);
  assign drop_evt = decide && i_no_match;

  // Packet statistics counters, wrapping at 2^32
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      passed_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (pass_evt) passed_q <= passed_q + 32'd1;
      if (drop_evt) dropped_q <= dropped_q + 32'd1;
    end
  end

  assign o_pkts_passed  = passed_q;
  assign o_pkts_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_ipmatch_gate.sv
// Self-checking bench for ipmatch_gate: per-cycle comparison against a
// packet-level queue model plus targeted checks per scenario.
module tb_ipmatch_gate;

  localparam int DECIDE_AT = 30;

  logic       clk = 1'b0;
  logic       rst_n, no_match, s_valid, s_last, s_abort;
  logic [7:0] s_data;
  logic       m_valid, m_last, m_abort;
  logic [7:0] m_data;
`ifdef IPMATCH_GATE_STATS_EN
  logic [31:0] pkts_passed, pkts_dropped;
`endif

  always #5 clk = ~clk;

  ipmatch_gate #(.DECIDE_AT(30), .LGFIFO(5)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_no_match   (no_match),
    .S_AXIN_VALID (s_valid),
    .S_AXIN_DATA  (s_data),
    .S_AXIN_LAST  (s_last),
    .S_AXIN_ABORT (s_abort),
    .M_AXIN_VALID (m_valid),
    .M_AXIN_DATA  (m_data),
    .M_AXIN_LAST  (m_last),
    .M_AXIN_ABORT (m_abort)
`ifdef IPMATCH_GATE_STATS_EN
    ,
    .o_pkts_passed  (pkts_passed),
    .o_pkts_dropped (pkts_dropped)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       a;
  } out_t;

  typedef enum {M_BUF, M_FWD, M_DROP} mode_t;

  // Reference model: bytes waiting for a verdict, bytes cleared to leave
  mode_t      mode = M_BUF;
  logic [8:0] held[$];
  logic [8:0] relq[$];
  int         m_passed = 0, m_dropped = 0;

  out_t       obs_q[$], exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] got_q[$];
  int         n_last, n_abort, first_v, last_at;
  int         n_checks = 0, n_pass = 0;

  task automatic step(input logic rstn, input logic v, input logic [7:0] d,
                      input logic l, input logic ab, input logic nm);
    out_t       e, o;
    logic [8:0] bb;
    rst_n = rstn; s_valid = v; s_data = d; s_last = l; s_abort = ab; no_match = nm;
    @(posedge clk);
    e = '0;
    if (!rstn) begin
      held.delete(); relq.delete(); mode = M_BUF; m_passed = 0; m_dropped = 0;
    end else begin
      if (relq.size() > 0) begin
        bb = relq.pop_front();
        e.v = 1'b1; e.d = bb[7:0]; e.l = bb[8];
      end
      case (mode)
        M_BUF: begin
          if (ab) held.delete();
          else if (v) begin
            held.push_back({l, d});
            if (l) begin
              foreach (held[k]) relq.push_back(held[k]);
              held.delete(); m_passed++;
            end else if (held.size() == DECIDE_AT) begin
              if (nm) begin held.delete(); mode = M_DROP; m_dropped++; end
              else begin
                foreach (held[k]) relq.push_back(held[k]);
                held.delete(); mode = M_FWD;
              end
            end
          end
        end
        M_FWD: begin
          if (ab) begin relq.delete(); e = '0; e.a = 1'b1; mode = M_BUF; end
          else if (v) begin
            relq.push_back({l, d});
            if (l) begin mode = M_BUF; m_passed++; end
          end
        end
        default: if (ab || (v && l)) mode = M_BUF;
      endcase
    end
    #1;
    o.v = m_valid; o.d = m_data; o.l = m_last; o.a = m_abort;
    obs_q.push_back(o);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic send_frame(input int len, input int abort_at, input int rst_at,
                            input logic nm_dec, input bit gaps);
    logic [7:0] d;
    int         g;
    for (int i = 0; i < len; i++) begin
      g = (gaps && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(1, 2)) : 0;
      for (int j = 0; j < g; j++)
        step(1'b1, 1'b0, 8'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      d = 8'($urandom);
      if (i == rst_at) begin step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0); return; end
      if (i == abort_at) begin step(1'b1, 1'b1, d, 1'($urandom), 1'b1, nm_dec); return; end
      sent_q.push_back(d);
      step(1'b1, 1'b1, d, 1'(i == len - 1), 1'b0, (i == DECIDE_AT - 1) ? nm_dec : 1'($urandom));
    end
  endtask

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete(); sent_q.delete();
  endtask

  // Summarises observed output: valid bytes, LAST/ABORT counts, first valid cycle
  task automatic tally();
    got_q.delete(); n_last = 0; n_abort = 0; first_v = -1; last_at = -1;
    foreach (obs_q[k]) begin
      if (obs_q[k].a) n_abort++;
      if (obs_q[k].v) begin
        if (first_v < 0) first_v = k;
        if (obs_q[k].l) begin n_last++; last_at = got_q.size(); end
        got_q.push_back(obs_q[k].d);
      end
    end
  endtask

  task automatic test_reset();
    clear_logs();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({m_valid, m_data, m_last, m_abort} !== 11'd0)
      $display("FAIL reset_outputs got v=%b d=%h l=%b a=%b want all 0", m_valid, m_data, m_last, m_abort);
    else n_pass++;
`ifdef IPMATCH_GATE_STATS_EN
    n_checks++;
    if (pkts_passed !== 32'd0 || pkts_dropped !== 32'd0)
      $display("FAIL reset_stats got %0d/%0d want 0/0", pkts_passed, pkts_dropped);
    else n_pass++;
`endif
  endtask

  task automatic test_match();
    bit ok;
    clear_logs();
    send_frame(60, -1, -1, 1'b0, 1'b0);
    idle(40);
    tally();
    n_checks++;
    if (first_v !== 30) $display("FAIL match_latency got cycle %0d want 30", first_v); else n_pass++;
    ok = (got_q.size() == 60);
    foreach (got_q[k]) if (k < sent_q.size() && got_q[k] !== sent_q[k]) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL match_data got %0d bytes want 60 in order", got_q.size()); else n_pass++;
    n_checks++;
    if (n_last !== 1 || last_at !== 59 || n_abort !== 0)
      $display("FAIL match_last got last=%0d at %0d abort=%0d want 1 at 59 abort 0", n_last, last_at, n_abort);
    else n_pass++;
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k])
        $display("FAIL match_stream cyc %0d got %b/%h/%b/%b want %b/%h/%b/%b", k, obs_q[k].v,
                 obs_q[k].d, obs_q[k].l, obs_q[k].a, exp_q[k].v, exp_q[k].d, exp_q[k].l, exp_q[k].a);
      else n_pass++;
    end
  endtask

  task automatic test_drop();
    bit ok;
    clear_logs();
    send_frame(60, -1, -1, 1'b1, 1'b0);
    idle(5);
    tally();
    n_checks++;
    if (got_q.size() !== 0 || n_abort !== 0)
      $display("FAIL drop_silent got %0d bytes abort=%0d want 0/0", got_q.size(), n_abort);
    else n_pass++;
    sent_q.delete();
    send_frame(60, -1, -1, 1'b0, 1'b0);
    idle(40);
    tally();
    ok = (got_q.size() == 60) && (n_last == 1) && (last_at == 59);
    foreach (got_q[k]) if (k < sent_q.size() && got_q[k] !== sent_q[k]) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL drop_next_frame got %0d bytes last=%0d want 60 intact", got_q.size(), n_last);
    else n_pass++;
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k])
        $display("FAIL drop_stream cyc %0d got %b/%h/%b/%b want %b/%h/%b/%b", k, obs_q[k].v,
                 obs_q[k].d, obs_q[k].l, obs_q[k].a, exp_q[k].v, exp_q[k].d, exp_q[k].l, exp_q[k].a);
      else n_pass++;
    end
  endtask

  task automatic test_short();
    bit ok;
    clear_logs();
    send_frame(20, -1, -1, 1'($urandom), 1'b0);
    idle(25);
    tally();
    n_checks++;
    if (first_v !== 20) $display("FAIL short_latency got cycle %0d want 20", first_v); else n_pass++;
    ok = (got_q.size() == 20) && (n_last == 1) && (last_at == 19);
    foreach (got_q[k]) if (k < sent_q.size() && got_q[k] !== sent_q[k]) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL short_data got %0d bytes last at %0d want 20, last at 19", got_q.size(), last_at);
    else n_pass++;
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k])
        $display("FAIL short_stream cyc %0d got %b/%h/%b/%b want %b/%h/%b/%b", k, obs_q[k].v,
                 obs_q[k].d, obs_q[k].l, obs_q[k].a, exp_q[k].v, exp_q[k].d, exp_q[k].l, exp_q[k].a);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_logs();
    send_frame(60, 15, -1, 1'b0, 1'b0);
    idle(10);
    tally();
    n_checks++;
    if (got_q.size() !== 0 || n_abort !== 0)
      $display("FAIL abort_hold got %0d bytes abort=%0d want 0/0", got_q.size(), n_abort);
    else n_pass++;
    clear_logs();
    send_frame(60, 40, -1, 1'b0, 1'b0);
    idle(40);
    tally();
    n_checks++;
    if (n_abort !== 1 || obs_q[40].a !== 1'b1)
      $display("FAIL abort_fwd_pulse got %0d pulses (cyc40=%b) want 1 at cyc 40", n_abort, obs_q[40].a);
    else n_pass++;
    ok = (got_q.size() == 10);
    foreach (got_q[k]) if (got_q[k] !== sent_q[k]) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL abort_fwd_flush got %0d bytes want first 10 only", got_q.size()); else n_pass++;
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k])
        $display("FAIL abort_stream cyc %0d got %b/%h/%b/%b want %b/%h/%b/%b", k, obs_q[k].v,
                 obs_q[k].d, obs_q[k].l, obs_q[k].a, exp_q[k].v, exp_q[k].d, exp_q[k].l, exp_q[k].a);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rst_idx;
    clear_logs();
    send_frame(25, -1, -1, 1'($urandom), 1'b0);
    send_frame(64, -1, -1, 1'b0, 1'b0);
    send_frame(64, -1, 35, 1'b0, 1'b0);
    rst_idx = obs_q.size() - 1;
    idle(40);
    tally();
    ok = (got_q.size() >= 89) && (n_last == 2);
    for (int k = 0; k < 89 && k < got_q.size(); k++) if (got_q[k] !== sent_q[k]) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL b2b_order got %0d bytes last=%0d want 25+64 in order, 2 LAST", got_q.size(), n_last);
    else n_pass++;
    ok = 1;
    for (int k = rst_idx; k < obs_q.size(); k++) if (obs_q[k] !== '0) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL b2b_reset_quiet got activity after reset want all outputs 0"); else n_pass++;
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k])
        $display("FAIL b2b_stream cyc %0d got %b/%h/%b/%b want %b/%h/%b/%b", k, obs_q[k].v,
                 obs_q[k].d, obs_q[k].l, obs_q[k].a, exp_q[k].v, exp_q[k].d, exp_q[k].l, exp_q[k].a);
      else n_pass++;
    end
  endtask

`ifdef IPMATCH_GATE_STATS_EN
  task automatic test_stats();
    clear_logs();
    for (int i = 0; i < 3; i++) begin send_frame(40, -1, -1, 1'b0, 1'b0); idle(40); end
    for (int i = 0; i < 2; i++) begin send_frame(40, -1, -1, 1'b1, 1'b0); idle(5); end
    send_frame(50, 35, -1, 1'b0, 1'b0);
    idle(40);
    n_checks++;
    if (pkts_passed !== 32'd3 || pkts_dropped !== 32'd2)
      $display("FAIL stats_counts got passed=%0d dropped=%0d want 3/2", pkts_passed, pkts_dropped);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    int len, ab;
    clear_logs();
    for (int f = 0; f < 25; f++) begin
      len = int'($urandom_range(1, 80));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      send_frame(len, ab, -1, 1'($urandom), 1'b1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(40);
    foreach (obs_q[k]) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k])
        $display("FAIL random_stream cyc %0d got %b/%h/%b/%b want %b/%h/%b/%b", k, obs_q[k].v,
                 obs_q[k].d, obs_q[k].l, obs_q[k].a, exp_q[k].v, exp_q[k].d, exp_q[k].l, exp_q[k].a);
      else n_pass++;
    end
`ifdef IPMATCH_GATE_STATS_EN
    n_checks++;
    if (pkts_passed !== 32'(m_passed) || pkts_dropped !== 32'(m_dropped))
      $display("FAIL random_stats got %0d/%0d want %0d/%0d", pkts_passed, pkts_dropped, m_passed, m_dropped);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_match();
    test_drop();
    test_short();
    test_abort();
    test_back_to_back();
`ifdef IPMATCH_GATE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ipmatch_gate.md
Name: ipmatch_gate

Overview:
- Sits directly downstream of the IP address matcher, on the same always-ready 8-bit receive byte stream.
- Holds the first DECIDE_AT bytes of each packet in a small FIFO until the matcher's verdict is valid.
- Then either releases the packet, cut-through, to the next stage, or discards it silently.
- Converts the matcher's per-byte no-match flag into actual packet removal.

Parameters:
- DECIDE_AT, 30: byte count at which i_no_match is sampled. The matcher's flag is valid from the cycle after byte index 28.
- LGFIFO, 5: log2 FIFO depth. 2^LGFIFO must be at least DECIDE_AT+1.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  synchronous, active-low reset
- i_no_match  in  1  verdict from ipmatch for the current packet
- S_AXIN_VALID  in  1  input byte valid; no READY, this block is always ready
- S_AXIN_DATA  in  8  input byte
- S_AXIN_LAST  in  1  final byte of packet
- S_AXIN_ABORT  in  1  upstream packet abort
- M_AXIN_VALID  out  1  output byte valid; downstream is always ready
- M_AXIN_DATA  out  8  output byte
- M_AXIN_LAST  out  1  final byte of forwarded packet
- M_AXIN_ABORT  out  1  forwarded packet aborted

Behaviour:
- Reset (i_reset_n low at a clock edge): all outputs 0; all FIFO pointers 0; byte count 0; state HOLD. Reset mid-packet discards everything, and no ABORT is emitted.
- FIFO entries are 9 bits {LAST, DATA}. Pointers wr, rel and rd are LGFIFO+1 bits wide and wrap modulo 2^(LGFIFO+1).
  - Entries from rd up to rel are released.
  - Entries from rel up to wr are held.
- Input byte count is 6 bits, saturates at DECIDE_AT and clears on LAST or ABORT.
- Every accepted byte (S_AXIN_VALID) is written at wr. Exception: in DROP, no byte is written.
- HOLD (buffering, verdict pending):
  - Accepted byte with LAST (count+1 ≤ DECIDE_AT): set rel to the new wr, so the whole short packet is released. Go to HOLD for the next packet.
  - Accepted byte that makes count == DECIDE_AT, with i_no_match=0 sampled that same edge: set rel to the new wr and go to FORWARD.
  - Same case with i_no_match=1: set wr back to rel, discarding the held bytes including this one, and go to DROP.
  - S_AXIN_ABORT: set wr back to rel. M_AXIN_ABORT stays 0, since nothing was emitted. Go to HOLD.
- FORWARD:
  - Each accepted byte advances wr and rel together.
  - LAST goes to HOLD.
  - S_AXIN_ABORT: flush (wr, rel and rd all set to wr), pulse M_AXIN_ABORT for 1 cycle on the next cycle, and go to HOLD. Exception: if M_AXIN_LAST has already been emitted for this packet, no ABORT is emitted.
- DROP: ignore input bytes. LAST or ABORT goes to HOLD. Nothing is emitted.
- ABORT takes precedence over a simultaneous VALID/LAST.
- Output side is registered with 1-cycle latency:
  - If rd != rel: M_AXIN_VALID=1 next cycle, DATA/LAST taken from FIFO[rd], rd++.
  - Otherwise M_AXIN_VALID=0.
  - Output runs at 1 byte/cycle.
- Cut-through latency from release to first output byte is 1 cycle.
- Depth guarantee: input is at most 1 byte/cycle and a released burst is at most DECIDE_AT bytes, so the previous packet is fully drained before the next packet's release. The FIFO never overflows. A full FIFO (wr−rd == 2^LGFIFO) is a design error and must be covered by an assertion.
- Empty FIFO is rd == rel.
- Simultaneous release and read in the same cycle is legal.

Optional Feature:
- IPMATCH_GATE_STATS_EN defined:
  - Adds outputs o_pkts_passed[31:0] and o_pkts_dropped[31:0], both reset to 0 and wrapping at 2^32.
  - passed increments on LAST accepted in FORWARD, or on the short-packet release in HOLD.
  - dropped increments on the HOLD→DROP transition.
  - Aborts count in neither.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- 60-byte IPv4 frame, i_no_match=0 at byte 30 -> bytes 0..29 appear back-to-back starting 1 cycle after byte 29 is accepted; all 60 bytes are output in order; M_AXIN_LAST only on byte 59; no ABORT.
- 60-byte frame, i_no_match=1 at byte 30 -> M_AXIN_VALID stays 0 for the whole packet; FIFO is empty afterward (rd==rel==wr); next matching frame passes intact.
- 20-byte frame with LAST at byte 19 -> all 20 bytes are released on LAST and output over 20 cycles with LAST on byte 19, regardless of i_no_match.
- ABORT at byte 15 (HOLD) -> no output and no M_AXIN_ABORT. ABORT at byte 40 in FORWARD -> exactly one M_AXIN_ABORT pulse, and the FIFO is flushed.
- Back-to-back frames: a 25-byte frame immediately followed by a 64-byte matching frame, VALID every cycle -> both frames are output in order with no loss or overflow assertion; i_reset_n pulled low at byte 35 of a third frame -> all outputs 0 the next cycle and nothing further is emitted.
- With IPMATCH_GATE_STATS_EN: 3 passing, 2 dropped and 1 aborted frame -> o_pkts_passed=3, o_pkts_dropped=2.
